rx_byte_packer: RTL and testbench

RX_BYTE_PACKER -- requirements
Module: rx_byte_packer

---
 rtl/rx_byte_packer_if.sv | 29 ++
 rtl/rx_byte_packer.sv | 234 +++++++++++++++++++++++
 tb/tb_rx_byte_packer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rx_byte_packer_if.sv
// Output word stream of the RX byte packer (AXI4-Stream style).
//   tdata  : packed 32-bit word, lane 0 in bits [7:0]
//   tkeep  : byte-lane enables
//   tlast  : last word of a packet record (the trailer)
//   tvalid : word available (output FIFO not empty)
//   tready : downstream accepts the word
interface rx_byte_packer_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (
    output tdata,
    output tkeep,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/rx_byte_packer.sv
// Packs a decoded PSDU byte stream into 32-bit records:
//   header word, data words (little-endian lanes), trailer word (tlast).
// Words are queued in a first-word-fall-through FIFO. One FIFO slot is
// always held back so a packet's trailer can never be dropped.
//
// Ports
//   clk, rstn                 : clock, async active-low reset
//   pkt_header_valid_strobe   : SIGNAL field decoded this cycle
//   pkt_header_valid          : SIGNAL field good
//   pkt_rate, pkt_len         : rate code and PSDU length of the header
//   byte_out_strobe, byte_out : one decoded byte
//   fcs_out_strobe, fcs_ok    : end of PSDU and its FCS result
//   receiver_rst              : watchdog abort of the current packet
//   m_axis                    : output word stream (master side)
//   busy                      : state is not IDLE
//   overflow_count            : words dropped for lack of space, saturating
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a good header strobe
// DATA    | packing bytes into the accumulator
// TRAILER | one cycle: push trailer word, then back to IDLE
module rx_byte_packer #(
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pkt_header_valid_strobe,
  input  logic        pkt_header_valid,
  input  logic [7:0]  pkt_rate,
  input  logic [15:0] pkt_len,
  input  logic        byte_out_strobe,
  input  logic [7:0]  byte_out,
  input  logic        fcs_out_strobe,
  input  logic        fcs_ok,
  input  logic        receiver_rst,
  rx_byte_packer_if.master m_axis,
  output logic        busy,
  output logic [15:0] overflow_count
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  typedef logic [FIFO_DEPTH_LOG2:0]   lvl_t;
  typedef logic [FIFO_DEPTH_LOG2-1:0] ptr_t;

  localparam lvl_t LVL_LIMIT = lvl_t'(DEPTH - 2);
  localparam lvl_t LVL_FULL  = lvl_t'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DATA    = 2'd1,
    S_TRAILER = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] acc_q, acc_d;
  logic        ovf_flag_q, ovf_flag_d;
  logic        abort_q, abort_d;
  logic        fcs_ok_q, fcs_ok_d;
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  logic [36:0] fifo_mem [DEPTH];
  ptr_t        wr_ptr_q, rd_ptr_q;
  lvl_t        level_q, level_d;

  logic        push;
  logic [36:0] push_word;
  logic        fifo_wr;
  logic        pop;
  logic        space_ok;
  logic        fifo_empty;

  // Next-state scratch for the DATA state
  logic [31:0] acc_v;
  logic [1:0]  lane_v;
  logic        word_full;
  logic        end_pkt;
  logic [3:0]  part_keep;

  assign fifo_empty = (level_q == '0);
  assign pop        = !fifo_empty && m_axis.tready;
  // Header/data pushes leave the last slot free for the trailer.
  assign space_ok   = (level_q <= LVL_LIMIT);
  assign fifo_wr    = push && ((level_q != LVL_FULL) || pop);

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    byte_cnt_d = byte_cnt_q;
    acc_d      = acc_q;
    ovf_flag_d = ovf_flag_q;
    abort_d    = abort_q;
    fcs_ok_d   = fcs_ok_q;
    ovf_cnt_d  = ovf_cnt_q;
    push       = 1'b0;
    push_word  = '0;
    acc_v      = acc_q;
    lane_v     = lane_q;
    word_full  = 1'b0;
    end_pkt    = 1'b0;
    part_keep  = 4'h0;

    case (state_q)
      S_IDLE: begin
        if (pkt_header_valid_strobe && pkt_header_valid) begin
          if (space_ok) begin
            push       = 1'b1;
            push_word  = {1'b0, 4'hF, 8'h00, pkt_rate, pkt_len};
            lane_d     = 2'd0;
            byte_cnt_d = 16'd0;
            acc_d      = 32'd0;
            ovf_flag_d = 1'b0;
            abort_d    = 1'b0;
            state_d    = S_DATA;
          end else if (ovf_cnt_q != 16'hFFFF) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
          end
        end
      end

      S_DATA: begin
        end_pkt = fcs_out_strobe || receiver_rst;
        // A byte coincident with end-of-packet is packed first.
        if (byte_out_strobe) begin
          acc_v[{lane_q, 3'b000} +: 8] = byte_out;
          byte_cnt_d = byte_cnt_q + 16'd1;
          lane_v     = lane_q + 2'd1;
          word_full  = (lane_q == 2'd3);
        end

        case (lane_v)
          2'd1:    part_keep = 4'h1;
          2'd2:    part_keep = 4'h3;
          2'd3:    part_keep = 4'h7;
          default: part_keep = 4'h0;
        endcase

        lane_d = lane_v;
        acc_d  = acc_v;

        if (word_full || (end_pkt && lane_v != 2'd0)) begin
          acc_d = 32'd0;
          if (space_ok) begin
            push      = 1'b1;
            push_word = {1'b0, (word_full ? 4'hF : part_keep), acc_v};
          end else begin
            ovf_flag_d = 1'b1;
            if (ovf_cnt_q != 16'hFFFF) begin
              ovf_cnt_d = ovf_cnt_q + 16'd1;
            end
          end
        end

        if (end_pkt) begin
          acc_d    = 32'd0;
          lane_d   = 2'd0;
          abort_d  = receiver_rst;
          fcs_ok_d = receiver_rst ? 1'b0 : fcs_ok;
          state_d  = S_TRAILER;
        end
      end

      S_TRAILER: begin
        push      = 1'b1;
        push_word = {1'b1, 4'hF, byte_cnt_q, 13'd0, abort_q, ovf_flag_q, fcs_ok_q};
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({fifo_wr, pop})
      2'b10:   level_d = level_q + lvl_t'(1);
      2'b01:   level_d = level_q - lvl_t'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      lane_q     <= 2'd0;
      byte_cnt_q <= 16'd0;
      acc_q      <= 32'd0;
      ovf_flag_q <= 1'b0;
      abort_q    <= 1'b0;
      fcs_ok_q   <= 1'b0;
      ovf_cnt_q  <= 16'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      byte_cnt_q <= byte_cnt_d;
      acc_q      <= acc_d;
      ovf_flag_q <= ovf_flag_d;
      abort_q    <= abort_d;
      fcs_ok_q   <= fcs_ok_d;
      ovf_cnt_q  <= ovf_cnt_d;
      level_q    <= level_d;
      if (fifo_wr) begin
        wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      end
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr_q] <= push_word;
    end
  end

  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = fifo_empty ? 32'd0 : fifo_mem[rd_ptr_q][31:0];
  assign m_axis.tkeep  = fifo_empty ? 4'h0  : fifo_mem[rd_ptr_q][35:32];
  assign m_axis.tlast  = fifo_empty ? 1'b0  : fifo_mem[rd_ptr_q][36];

  assign busy           = (state_q != S_IDLE);
  assign overflow_count = ovf_cnt_q;

endmodule

// File: tb/tb_rx_byte_packer.sv
// Directed bench for rx_byte_packer with hand-computed expected words.
module tb_rx_byte_packer;

  logic        clk;
  logic        rstn;
  logic        pkt_header_valid_strobe;
  logic        pkt_header_valid;
  logic [7:0]  pkt_rate;
  logic [15:0] pkt_len;
  logic        byte_out_strobe;
  logic [7:0]  byte_out;
  logic        fcs_out_strobe;
  logic        fcs_ok;
  logic        receiver_rst;
  logic        busy;
  logic [15:0] overflow_count;

  rx_byte_packer_if m_axis_if ();

  rx_byte_packer #(.FIFO_DEPTH_LOG2(3)) dut (
    .clk                     (clk),
    .rstn                    (rstn),
    .pkt_header_valid_strobe (pkt_header_valid_strobe),
    .pkt_header_valid        (pkt_header_valid),
    .pkt_rate                (pkt_rate),
    .pkt_len                 (pkt_len),
    .byte_out_strobe         (byte_out_strobe),
    .byte_out                (byte_out),
    .fcs_out_strobe          (fcs_out_strobe),
    .fcs_ok                  (fcs_ok),
    .receiver_rst            (receiver_rst),
    .m_axis                  (m_axis_if),
    .busy                    (busy),
    .overflow_count          (overflow_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [36:0] rx_q [$];

  // Record each word at the falling edge before the rising edge that pops it.
  always @(negedge clk) begin
    if (rstn && m_axis_if.tvalid && m_axis_if.tready) begin
      rx_q.push_back({m_axis_if.tlast, m_axis_if.tkeep, m_axis_if.tdata});
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
    logic [36:0] w;
    int budget;
    budget = 64;
    while (rx_q.size() == 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (rx_q.size() == 0) begin
      check_val({tag, "_present"}, 64'(rx_q.size()), 64'd1);
    end else begin
      w = rx_q.pop_front();
      check_val(tag, 64'(w), 64'({l, k, d}));
    end
  endtask

  task automatic send_hdr(input logic v, input logic [7:0] rate, input logic [15:0] len);
    pkt_header_valid_strobe = 1'b1;
    pkt_header_valid        = v;
    pkt_rate                = rate;
    pkt_len                 = len;
    tick();
    pkt_header_valid_strobe = 1'b0;
    pkt_header_valid        = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic with_fcs, input logic ok);
    byte_out_strobe = 1'b1;
    byte_out        = b;
    fcs_out_strobe  = with_fcs;
    fcs_ok          = ok;
    tick();
    byte_out_strobe = 1'b0;
    fcs_out_strobe  = 1'b0;
    fcs_ok          = 1'b0;
  endtask

  task automatic send_fcs(input logic ok);
    fcs_out_strobe = 1'b1;
    fcs_ok         = ok;
    tick();
    fcs_out_strobe = 1'b0;
    fcs_ok         = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    pkt_header_valid_strobe = 1'b0;
    pkt_header_valid = 1'b0;
    pkt_rate = 8'h00;
    pkt_len = 16'h0000;
    byte_out_strobe = 1'b0;
    byte_out = 8'h00;
    fcs_out_strobe = 1'b0;
    fcs_ok = 1'b0;
    receiver_rst = 1'b0;
    m_axis_if.tready = 1'b1;

    // Reset state
    wait_cycles(3);
    check_val("rst_tvalid", 64'(m_axis_if.tvalid), 64'd0);
    check_val("rst_tdata", 64'(m_axis_if.tdata), 64'd0);
    check_val("rst_tkeep", 64'(m_axis_if.tkeep), 64'd0);
    check_val("rst_tlast", 64'(m_axis_if.tlast), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_ovf", 64'(overflow_count), 64'd0);
    rstn = 1'b1;
    wait_cycles(2);

    // Basic 6-byte packet
    send_hdr(1'b1, 8'h0B, 16'd6);
    check_val("p1_busy", 64'(busy), 64'd1);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0, 1'b0);
    send_fcs(1'b1);
    expect_word("p1_hdr", 32'h000B0006, 4'hF, 1'b0);
    expect_word("p1_w0", 32'h04030201, 4'hF, 1'b0);
    expect_word("p1_w1", 32'h00000605, 4'h3, 1'b0);
    expect_word("p1_trl", 32'h00060001, 4'hF, 1'b1);
    check_val("p1_busy_end", 64'(busy), 64'd0);

    // FCS coincident with the 4th byte: no empty partial word
    send_hdr(1'b1, 8'h0C, 16'd4);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'hCC, 1'b0, 1'b0);
    send_byte(8'hDD, 1'b1, 1'b1);
    expect_word("p2_hdr", 32'h000C0004, 4'hF, 1'b0);
    expect_word("p2_w0", 32'hDDCCBBAA, 4'hF, 1'b0);
    expect_word("p2_trl", 32'h00040001, 4'hF, 1'b1);
    wait_cycles(5);
    check_val("p2_no_extra", 64'(rx_q.size()), 64'd0);

    // Watchdog abort after 5 bytes
    send_hdr(1'b1, 8'h01, 16'd5);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h11 + i), 1'b0, 1'b0);
    receiver_rst = 1'b1;
    tick();
    receiver_rst = 1'b0;
    expect_word("p3_hdr", 32'h00010005, 4'hF, 1'b0);
    expect_word("p3_w0", 32'h14131211, 4'hF, 1'b0);
    expect_word("p3_w1", 32'h00000015, 4'h1, 1'b0);
    expect_word("p3_trl", 32'h00050004, 4'hF, 1'b1);

    // Invalid header: everything ignored
    send_hdr(1'b0, 8'h0D, 16'd3);
    check_val("p4_busy", 64'(busy), 64'd0);
    send_byte(8'h55, 1'b0, 1'b0);
    send_byte(8'h66, 1'b0, 1'b0);
    send_fcs(1'b1);
    check_val("p4_busy2", 64'(busy), 64'd0);
    wait_cycles(5);
    check_val("p4_no_words", 64'(rx_q.size()), 64'd0);
    check_val("p4_tvalid", 64'(m_axis_if.tvalid), 64'd0);

    // Back-pressure: 40 bytes with tready low
    m_axis_if.tready = 1'b0;
    send_hdr(1'b1, 8'h0B, 16'd40);
    for (int i = 0; i < 40; i++) send_byte(8'(i), 1'b0, 1'b0);
    send_fcs(1'b1);
    wait_cycles(2);
    check_val("p5_ovf_cnt", 64'(overflow_count), 64'd4);
    check_val("p5_busy", 64'(busy), 64'd0);
    check_val("p5_tvalid", 64'(m_axis_if.tvalid), 64'd1);
    m_axis_if.tready = 1'b1;
    expect_word("p5_hdr", 32'h000B0028, 4'hF, 1'b0);
    for (int k = 0; k < 6; k++) begin
      expect_word($sformatf("p5_w%0d", k),
                  {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}, 4'hF, 1'b0);
    end
    expect_word("p5_trl", 32'h00280003, 4'hF, 1'b1);
    wait_cycles(5);
    check_val("p5_drained", 64'(rx_q.size()), 64'd0);
    check_val("p5_tvalid_end", 64'(m_axis_if.tvalid), 64'd0);

    // Reset while 3 words are buffered
    m_axis_if.tready = 1'b0;
    send_hdr(1'b1, 8'h0E, 16'd8);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h80 + i), 1'b0, 1'b0);
    check_val("p6_pre_tvalid", 64'(m_axis_if.tvalid), 64'd1);
    rstn = 1'b0;
    #1;
    check_val("p6_rst_tvalid", 64'(m_axis_if.tvalid), 64'd0);
    check_val("p6_rst_tdata", 64'(m_axis_if.tdata), 64'd0);
    check_val("p6_rst_ovf", 64'(overflow_count), 64'd0);
    check_val("p6_rst_busy", 64'(busy), 64'd0);
    wait_cycles(2);
    rstn = 1'b1;
    wait_cycles(1);
    rx_q.delete();
    m_axis_if.tready = 1'b1;
    send_hdr(1'b1, 8'h22, 16'd1);
    send_byte(8'h7E, 1'b0, 1'b0);
    send_fcs(1'b0);
    expect_word("p6_hdr", 32'h00220001, 4'hF, 1'b0);
    expect_word("p6_w0", 32'h0000007E, 4'h1, 1'b0);
    expect_word("p6_trl", 32'h00010000, 4'hF, 1'b1);
    wait_cycles(5);
    check_val("p6_drained", 64'(rx_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
